muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_divstep.sv | 21 ++
 rtl/muldiv_iter.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM states and default widths.
package md_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ITER_DEF = 32;

    typedef enum logic [2:0] {
        FN_NONE = 3'b000,
        FN_MULT = 3'b001,
        FN_DIV  = 3'b010,
        FN_MTHI = 3'b011,
        FN_MTLO = 3'b100
    } md_func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_divstep.sv
// One restoring shift-subtract division step on magnitude operands.
module md_divstep #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic          w_ge;

    // Partial remainder stays below the divisor, so the result always fits XLEN bits.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, i_dvsr});
    assign o_rem   = w_ge ? XLEN'(w_shift - {1'b0, i_dvsr}) : w_shift[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit (radix-2 shift-add MULT, restoring DIV).
// Optional MD_EARLY_OUT_EN: MULT finishes once the remaining multiplier bits are zero.
module muldiv_iter
    import md_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned ITER = ITER_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      F,
    input  logic            isSign,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] O_HI,
    output logic [XLEN-1:0] O_LO
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned PW    = 2 * XLEN;

    md_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]    r_acc, w_acc_nxt;
    logic [PW-1:0]    r_mcand, w_mcand_nxt;
    logic [XLEN-1:0]  r_opb, w_opb_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             r_bzero, w_bzero_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_busy, r_done, w_done_nxt;
    logic [XLEN-1:0]  r_hi, w_hi_nxt;
    logic [XLEN-1:0]  r_lo, w_lo_nxt;

    logic [XLEN-1:0]  w_abs_a, w_abs_b;
    logic [XLEN-1:0]  w_rem, w_quo;
    logic [XLEN-1:0]  w_ds_rem, w_ds_quo;
    logic             w_last;

    assign w_abs_a = (isSign && A[XLEN-1]) ? (XLEN'(0) - A) : A;
    assign w_abs_b = (isSign && B[XLEN-1]) ? (XLEN'(0) - B) : B;
    assign w_rem   = r_acc[PW-1:XLEN];
    assign w_quo   = r_acc[XLEN-1:0];
    assign w_last  = (r_cnt == CNT_W'(ITER - 1));

    // During DIV the accumulator holds {partial remainder, dividend/quotient}.
    md_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem  (w_rem),
        .i_quo  (w_quo),
        .i_dvsr (r_opb),
        .o_rem  (w_ds_rem),
        .o_quo  (w_ds_quo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_opb_nxt    = r_opb;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_bzero_nxt  = r_bzero;
        w_is_div_nxt = r_is_div;
        w_done_nxt   = 1'b0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;

        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    case (F)
                        FN_MULT, FN_DIV: begin
                            w_state_nxt  = (F == FN_MULT) ? MUL : DIV;
                            w_cnt_nxt    = '0;
                            w_opb_nxt    = w_abs_b;
                            w_neg_q_nxt  = isSign & (A[XLEN-1] ^ B[XLEN-1]);
                            w_neg_r_nxt  = isSign & A[XLEN-1];
                            w_bzero_nxt  = (B == '0);
                            w_is_div_nxt = (F == FN_DIV);
                            if (F == FN_MULT) begin
                                w_acc_nxt   = '0;
                                w_mcand_nxt = {XLEN'(0), w_abs_a};
                            end else begin
                                w_acc_nxt   = {XLEN'(0), w_abs_a};
                                w_mcand_nxt = '0;
                            end
                        end
                        FN_MTHI: begin
                            w_hi_nxt   = A;
                            w_done_nxt = 1'b1;
                        end
                        FN_MTLO: begin
                            w_lo_nxt   = A;
                            w_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (r_opb[0]) begin
                    w_acc_nxt = r_acc + r_mcand;
                end
                w_mcand_nxt = r_mcand << 1;
                w_opb_nxt   = r_opb >> 1;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifdef MD_EARLY_OUT_EN
                if ((r_opb[XLEN-1:1] == '0) || w_last) begin
                    w_state_nxt = FIX;
                end
`else
                if (w_last) begin
                    w_state_nxt = FIX;
                end
`endif
            end
            DIV: begin
                w_acc_nxt = {w_ds_rem, w_ds_quo};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                if (r_is_div) begin
                    // Divide by zero: quotient all ones, remainder returns the dividend.
                    w_lo_nxt = r_bzero ? '1 : (r_neg_q ? (XLEN'(0) - w_quo) : w_quo);
                    w_hi_nxt = r_neg_r ? (XLEN'(0) - w_rem) : w_rem;
                end else begin
                    {w_hi_nxt, w_lo_nxt} = r_neg_q ? (PW'(0) - r_acc) : r_acc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A flush abandons the op without touching HI/LO.
        if (cancel && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_opb    <= w_opb_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_bzero  <= w_bzero_nxt;
            r_is_div <= w_is_div_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign O_HI = r_hi;
    assign O_LO = r_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter; expected latencies follow MD_EARLY_OUT_EN when defined.
module tb_muldiv_iter;

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  F = 3'b000;
    logic        isSign = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] O_HI, O_LO;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_iter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .F      (F),
        .isSign (isSign),
        .A      (A),
        .B      (B),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .O_HI   (O_HI),
        .O_LO   (O_LO)
    );

    always #5 clk = ~clk;

    // Issue one MULT/DIV, return the edge index Ek after which done was seen (-1 on timeout).
    task automatic run_op(input logic [2:0] f, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic busy_e0);
        @(negedge clk);
        start = 1'b1; F = f; isSign = sgn; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; F = 3'b000;
        busy_e0 = busy;
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (O_HI !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h exp 0", O_HI); end
        n_cmp++; if (O_LO !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h exp 0", O_LO); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult_unsigned;
        int lat; logic b0;
        run_op(3'b001, 1'b0, 32'hFFFF_FFFF, 32'h2, lat, b0);
        n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL mulu_busy got %b exp 1", b0); end
        n_cmp++; if (lat !== (EARLY ? 3 : 33)) begin n_bad++; $display("FAIL mulu_lat got %0d exp %0d", lat, EARLY ? 3 : 33); end
        n_cmp++; if (O_HI !== 32'h0000_0001) begin n_bad++; $display("FAIL mulu_hi got %h exp 00000001", O_HI); end
        n_cmp++; if (O_LO !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mulu_lo got %h exp fffffffe", O_LO); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mulu_busy_end got %b exp 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mulu_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_div;
        int lat; logic b0;
        run_op(3'b010, 1'b1, 32'hFFFF_FFF9, 32'h2, lat, b0);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divs_lat got %0d exp 33", lat); end
        n_cmp++; if (O_LO !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL divs_lo got %h exp fffffffd", O_LO); end
        n_cmp++; if (O_HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divs_hi got %h exp ffffffff", O_HI); end
        run_op(3'b010, 1'b0, 32'h5, 32'h0, lat, b0);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div0_lat got %0d exp 33", lat); end
        n_cmp++; if (O_LO !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_lo got %h exp ffffffff", O_LO); end
        n_cmp++; if (O_HI !== 32'h0000_0005) begin n_bad++; $display("FAIL div0_hi got %h exp 00000005", O_HI); end
        run_op(3'b010, 1'b0, 32'd100, 32'd7, lat, b0);
        n_cmp++; if (O_LO !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h exp 0000000e", O_LO); end
        n_cmp++; if (O_HI !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h exp 00000002", O_HI); end
    endtask

    task automatic test_mult_signed;
        int lat; logic b0;
        run_op(3'b001, 1'b1, 32'hFFFF_FFFD, 32'h5, lat, b0);
        n_cmp++; if (lat !== (EARLY ? 4 : 33)) begin n_bad++; $display("FAIL muls_lat got %0d exp %0d", lat, EARLY ? 4 : 33); end
        n_cmp++; if (O_HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL muls_hi got %h exp ffffffff", O_HI); end
        n_cmp++; if (O_LO !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL muls_lo got %h exp fffffff1", O_LO); end
        run_op(3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0);
        n_cmp++; if (O_LO !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo got %h exp 80000000", O_LO); end
        n_cmp++; if (O_HI !== 32'h0) begin n_bad++; $display("FAIL divovf_hi got %h exp 00000000", O_HI); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1; F = 3'b011; A = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mthi_done got %b exp 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b exp 0", busy); end
        n_cmp++; if (O_HI !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi got %h exp 00001234", O_HI); end
        F = 3'b100; A = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; F = 3'b000;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mtlo_done got %b exp 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got %b exp 0", busy); end
        n_cmp++; if (O_LO !== 32'h5678) begin n_bad++; $display("FAIL mtlo_lo got %h exp 00005678", O_LO); end
        n_cmp++; if (O_HI !== 32'h1234) begin n_bad++; $display("FAIL mtlo_hi_kept got %h exp 00001234", O_HI); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mtlo_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_ignored;
        logic saw;
        saw = 1'b0;
        @(negedge clk);
        start = 1'b1; F = 3'b000; A = 32'hDEAD;
        @(negedge clk);
        saw = saw | done | busy;
        F = 3'b111;
        @(negedge clk);
        saw = saw | done | busy;
        F = 3'b011; cancel = 1'b1;
        @(negedge clk);
        saw = saw | done | busy;
        start = 1'b0; F = 3'b000; cancel = 1'b0;
        @(negedge clk);
        saw = saw | done | busy;
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL ignore_activity got %b exp 0", saw); end
        n_cmp++; if (O_HI !== 32'h1234) begin n_bad++; $display("FAIL ignore_hi got %h exp 00001234", O_HI); end
        n_cmp++; if (O_LO !== 32'h5678) begin n_bad++; $display("FAIL ignore_lo got %h exp 00005678", O_LO); end
    endtask

    task automatic test_cancel;
        logic saw;
        @(negedge clk);
        start = 1'b1; F = 3'b010; isSign = 1'b0; A = 32'd100; B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; F = 3'b000;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 4) begin start = 1'b1; F = 3'b001; A = 32'd3; B = 32'd4; end
            if (e == 5) begin start = 1'b0; F = 3'b000; end
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cancel_busy_before got %b exp 1", busy); end
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy_after got %b exp 0", busy); end
        saw = done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw = saw | done | busy;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL cancel_quiet got %b exp 0", saw); end
        n_cmp++; if (O_HI !== 32'h1234) begin n_bad++; $display("FAIL cancel_hi got %h exp 00001234", O_HI); end
        n_cmp++; if (O_LO !== 32'h5678) begin n_bad++; $display("FAIL cancel_lo got %h exp 00005678", O_LO); end
    endtask

    task automatic test_mult_small;
        int lat; logic b0;
        run_op(3'b001, 1'b0, 32'd7, 32'd1, lat, b0);
        n_cmp++; if (lat !== (EARLY ? 2 : 33)) begin n_bad++; $display("FAIL mul71_lat got %0d exp %0d", lat, EARLY ? 2 : 33); end
        n_cmp++; if (O_LO !== 32'd7) begin n_bad++; $display("FAIL mul71_lo got %h exp 00000007", O_LO); end
        n_cmp++; if (O_HI !== 32'd0) begin n_bad++; $display("FAIL mul71_hi got %h exp 00000000", O_HI); end
        run_op(3'b001, 1'b0, 32'h1234_5678, 32'd0, lat, b0);
        n_cmp++; if (lat !== (EARLY ? 2 : 33)) begin n_bad++; $display("FAIL mulz_lat got %0d exp %0d", lat, EARLY ? 2 : 33); end
        n_cmp++; if ({O_HI, O_LO} !== 64'h0) begin n_bad++; $display("FAIL mulz_res got %h exp 0", {O_HI, O_LO}); end
    endtask

    task automatic test_reset_mid_op;
        int lat; logic b0;
        @(negedge clk);
        start = 1'b1; F = 3'b010; isSign = 1'b0; A = 32'd50; B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; F = 3'b000;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b exp 0", done); end
        n_cmp++; if (O_HI !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h exp 0", O_HI); end
        n_cmp++; if (O_LO !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h exp 0", O_LO); end
        @(negedge clk);
        rst = 1'b1;
        run_op(3'b001, 1'b0, 32'd6, 32'd7, lat, b0);
        n_cmp++; if (lat !== (EARLY ? 4 : 33)) begin n_bad++; $display("FAIL post_rst_lat got %0d exp %0d", lat, EARLY ? 4 : 33); end
        n_cmp++; if (O_LO !== 32'd42) begin n_bad++; $display("FAIL post_rst_lo got %h exp 0000002a", O_LO); end
        n_cmp++; if (O_HI !== 32'd0) begin n_bad++; $display("FAIL post_rst_hi got %h exp 00000000", O_HI); end
    endtask

    initial begin
        test_reset();
        test_mult_unsigned();
        test_div();
        test_mult_signed();
        test_mthi_mtlo();
        test_ignored();
        test_cancel();
        test_mult_small();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
